// File: rtl/dot_accumulator.sv
// ---------------------------------------------------------------------------
// dot_accumulator
//
// Sits behind the fixed-point multiplier. Sums LEN consecutive signed products
// into a saturating accumulator, then rescales the finished sum from IN_FRAC
// to OUT_FRAC fraction bits and saturates it to OUT_WIDTH. Each result is held
// in an output register with a valid/ready handshake. The stall_out output is
// the back-pressure signal for the multiplier's stall input.
//
// Optional feature macro:
//   DOT_ACC_ROUND_EN  defined   -> round-half-up when rescaling
//                     undefined -> truncation (floor) when rescaling
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   stall      in   global pipeline stall (freezes acc/count, no take)
//   clear      in   abort the current partial sum (product that cycle dropped)
//   in_valid   in   product valid (multiplier done)
//   in_data    in   signed product, IN_WIDTH bits, IN_FRAC fraction bits
//   stall_out  out  back-pressure; a product presented while high is not taken
//   out_valid  out  output register holds an unconsumed result
//   out_data   out  signed result, OUT_WIDTH bits, OUT_FRAC fraction bits
//   out_ready  in   downstream accepts the result when out_valid & out_ready
//   busy       out  a partial sum is in progress (count != 0)
// ---------------------------------------------------------------------------
module dot_accumulator #(
    parameter int IN_WIDTH  = 16,
    parameter int IN_FRAC   = 15,
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 16,
    parameter int OUT_FRAC  = 13,
    parameter int LEN       = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        clear,
    input  logic                        in_valid,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    output logic                        stall_out,
    output logic                        out_valid,
    output logic signed [OUT_WIDTH-1:0] out_data,
    input  logic                        out_ready,
    output logic                        busy
);

    localparam int SHIFT = IN_FRAC - OUT_FRAC;
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    // Rounding bias: half an output LSB, or nothing when no bits are dropped.
    localparam logic signed [ACC_WIDTH:0] ROUND_BIAS =
        (SHIFT > 0) ? ((ACC_WIDTH+1)'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0))
                    : (ACC_WIDTH+1)'(0);

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------

    // Saturate a one-bit-wider sum back into the accumulator range. Overflow
    // shows up as the two top bits disagreeing; the top bit gives the sign.
    function automatic logic signed [ACC_WIDTH-1:0] sat_acc(
        input logic signed [ACC_WIDTH:0] v
    );
        logic signed [ACC_WIDTH-1:0] r;
        if (v[ACC_WIDTH] != v[ACC_WIDTH-1]) begin
            if (v[ACC_WIDTH]) begin
                r = {1'b1, {(ACC_WIDTH-1){1'b0}}};
            end else begin
                r = {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end else begin
            r = v[ACC_WIDTH-1:0];
        end
        return r;
    endfunction

    // Rescale a finished sum to the output format and saturate it. Work is
    // done one bit wider than the accumulator so the rounding bias can never
    // overflow.
    function automatic logic signed [OUT_WIDTH-1:0] scale_out(
        input logic signed [ACC_WIDTH-1:0] sum
    );
        logic signed [ACC_WIDTH:0]           ext;
        logic signed [ACC_WIDTH:0]           shifted;
        logic [ACC_WIDTH-OUT_WIDTH+1:0]      upper;
        logic signed [OUT_WIDTH-1:0]         r;
        ext = {sum[ACC_WIDTH-1], sum};
`ifdef DOT_ACC_ROUND_EN
        ext = ext + ROUND_BIAS;
`else
        ext = ext + (ACC_WIDTH+1)'(0) * ROUND_BIAS;
`endif
        shifted = ext >>> SHIFT;
        // In range exactly when every bit from the output sign bit upward
        // is a copy of the sign.
        upper = shifted[ACC_WIDTH:OUT_WIDTH-1];
        if ((&upper) || (~|upper)) begin
            r = shifted[OUT_WIDTH-1:0];
        end else if (shifted[ACC_WIDTH]) begin
            r = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            r = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic signed [ACC_WIDTH-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0]            count_q,     count_d;
    logic                        out_valid_q, out_valid_d;
    logic signed [OUT_WIDTH-1:0] out_data_q,  out_data_d;
    logic                        busy_q,      busy_d;

    logic                        last;
    logic                        take;
    logic signed [ACC_WIDTH-1:0] acc_sum;

    // Back-pressure, take decision and the saturated running sum.
    always_comb begin
        last      = (count_q == LAST_CNT);
        // Only the completing product needs a free output register; partial
        // sums keep flowing while a result waits.
        stall_out = out_valid_q & ~out_ready & last & in_valid;
        take      = in_valid & ~stall & ~stall_out & ~clear;
        acc_sum   = sat_acc({acc_q[ACC_WIDTH-1], acc_q} +
                            {{(ACC_WIDTH+1-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data});
    end

    // Next-state logic for the accumulator and the output register.
    always_comb begin
        acc_d       = acc_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        // Handshake runs independently of stall.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (clear) begin
            acc_d   = {ACC_WIDTH{1'b0}};
            count_d = {CNT_W{1'b0}};
        end else if (take) begin
            if (last) begin
                // A new result overrides the handshake clear above, so
                // out_valid stays high when consume and load coincide.
                acc_d       = {ACC_WIDTH{1'b0}};
                count_d     = {CNT_W{1'b0}};
                out_data_d  = scale_out(acc_sum);
                out_valid_d = 1'b1;
            end else begin
                acc_d   = acc_sum;
                count_d = count_q + CNT_W'(1);
            end
        end else begin
            acc_d   = acc_q;
            count_d = count_q;
        end

        busy_d = (count_d != {CNT_W{1'b0}});
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= {ACC_WIDTH{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {OUT_WIDTH{1'b0}};
            busy_q      <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dot_accumulator.sv
// ---------------------------------------------------------------------------
// tb_dot_accumulator
//
// Drives two instances (LEN=4 and LEN=8) of dot_accumulator. Expected results
// are computed from integer arithmetic when a product is accepted, pushed
// into a queue and compared when the DUT hands the result over.
// ---------------------------------------------------------------------------
module tb_dot_accumulator;

    localparam int OW    = 16;
    localparam int AW    = 32;
    localparam int SHIFT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, stall, clear, in_valid, out_ready;
    logic signed [15:0] in_data;
    logic               stall_out, out_valid, busy;
    logic signed [15:0] out_data;

    logic               in_valid8, out_ready8;
    logic signed [15:0] in_data8;
    logic               stall_out8, out_valid8, busy8;
    logic signed [15:0] out_data8;

    dot_accumulator #(.LEN(4)) u_dut (
        .clk(clk), .reset(reset), .stall(stall), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .stall_out(stall_out),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy)
    );

    dot_accumulator #(.LEN(8)) u_dut8 (
        .clk(clk), .reset(reset), .stall(stall), .clear(clear),
        .in_valid(in_valid8), .in_data(in_data8), .stall_out(stall_out8),
        .out_valid(out_valid8), .out_data(out_data8), .out_ready(out_ready8),
        .busy(busy8)
    );

    int     total = 0;
    int     bad   = 0;
    int     n_pushed = 0;
    int     n_seen   = 0;
    longint q4[$];
    longint q8[$];
    longint m_acc = 0;
    int     m_cnt = 0;
    longint m8_acc = 0;
    int     m8_cnt = 0;

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sat_w(input longint v, input int w);
        longint mx;
        longint mn;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -(longint'(1) <<< (w - 1));
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    // Rescale: floor division by 2^SHIFT, optionally after adding half an LSB.
    function automatic longint expect_res(input longint sum);
        longint r;
        longint d;
        r = sum;
`ifdef DOT_ACC_ROUND_EN
        r = r + (longint'(1) <<< (SHIFT - 1));
`endif
        d = longint'(1) <<< SHIFT;
        // Floor division that also holds for negative numerators.
        if (r >= 0) r = r / d;
        else        r = -((-r + d - 1) / d);
        return sat_w(r, OW);
    endfunction

    // Result monitor for both instances.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (q4.size() == 0) begin
                    chk("extra_result4", q4.size(), 1);
                end else begin
                    n_seen++;
                    chk("result4", out_data, q4.pop_front());
                end
            end
            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) begin
                    chk("extra_result8", q8.size(), 1);
                end else begin
                    n_seen++;
                    chk("result8", out_data8, q8.pop_front());
                end
            end
        end
    end

    task automatic send(input int d);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d[15:0];
        forever begin
            @(negedge clk);
            if (!stall && !clear && !stall_out) begin
                m_acc = sat_w(m_acc + longint'(d), AW);
                m_cnt++;
                if (m_cnt == 4) begin
                    q4.push_back(expect_res(m_acc));
                    n_pushed++;
                    m_acc = 0;
                    m_cnt = 0;
                end
                break;
            end
            t++;
            if (t > 50) begin
                chk("send_timeout", t, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send8(input int d);
        int t;
        t = 0;
        in_valid8 = 1'b1;
        in_data8  = d[15:0];
        forever begin
            @(negedge clk);
            if (!stall && !clear && !stall_out8) begin
                m8_acc = sat_w(m8_acc + longint'(d), AW);
                m8_cnt++;
                if (m8_cnt == 8) begin
                    q8.push_back(expect_res(m8_acc));
                    n_pushed++;
                    m8_acc = 0;
                    m8_cnt = 0;
                end
                break;
            end
            t++;
            if (t > 50) begin
                chk("send8_timeout", t, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
    endtask

    task automatic vec(input int a, input int b, input int c, input int d);
        send(a);
        send(b);
        send(c);
        send(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; clear = 1'b0;
        in_valid = 1'b0; in_data = 16'sd0; out_ready = 1'b1;
        in_valid8 = 1'b0; in_data8 = 16'sd0; out_ready8 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_stall_out", stall_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid8", out_valid8, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset in the middle of a sum discards the partial sum.
        send(1000);
        send(2000);
        @(negedge clk);
        chk("busy_mid", busy, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        m_acc = 0; m_cnt = 0; q4.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        vec(4096, 4096, 4096, 4096);

        // Basic sum and completion latency.
        send(8192); send(8192); send(8192);
        chk("pre_done", out_valid, 0);
        send(8192);
        chk("done_latency", out_valid, 1);
        @(posedge clk); #1;

        // Saturation to the output range.
        vec(32767, 32767, 32767, 32767);
        vec(-32768, -32768, -32768, -32768);
        for (int i = 0; i < 8; i++) send8(32767);
        for (int i = 0; i < 8; i++) send8(-32768);
        @(posedge clk); #1;

        // Back-pressure: second result blocked until the first is consumed.
        out_ready = 1'b0;
        vec(4096, 4096, 4096, 4096);
        send(4096); send(4096); send(4096);
        fork
            send(8192);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_out_held", stall_out, 1);
                    chk("held_data", out_data, 4096);
                    chk("held_busy", busy, 1);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        chk("ov_kept", out_valid, 1);
        @(posedge clk); #1;

        // Stall mid-vector freezes the partial sum.
        send(1000); send(2000);
        fork
            send(3000);
            begin
                stall = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_busy", busy, 1);
                end
                @(posedge clk); #1;
                stall = 1'b0;
            end
        join
        send(4000);

        // Clear with a valid product: product dropped, fresh sum follows.
        send(100); send(200);
        in_valid = 1'b1; in_data = 16'sd300; clear = 1'b1;
        m_acc = 0; m_cnt = 0;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("clear_busy", busy, 0);
        @(posedge clk); #1;
        vec(400, 800, 1200, 1600);

        // Rescaling: truncation or round-half-up depending on build.
        vec(2, 2, 2, 0);
        vec(-2, -2, -2, 0);
        vec(3, 2, 2, 0);
        vec(-3, -1, -1, 0);

        begin
            int t;
            t = 0;
            while ((q4.size() != 0 || q8.size() != 0) && t < 100) begin
                @(posedge clk);
                t++;
            end
        end
        @(negedge clk);
        chk("q4_empty", q4.size(), 0);
        chk("q8_empty", q8.size(), 0);
        chk("result_count", n_seen, n_pushed);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
